ctrl_pipeline: RTL and testbench
================================

// Module: ctrl_pipeline
// PURPOSE
//  Receives the wb/mem/ex control bundles produced by decode and carries them through the ID/EX, EX/MEM and MEM/WB registers.
//  Unpacks them into per-stage strobes.
//  Detects load-use hazards (stall and bubble) and resolves branches in MEM (flush).
//  Counts retired instructions.
//  Sits between decode control and the EX/MEM/WB datapath, fetch and regfile.
// PARAMETERS
//  REG_W   5   register-specifier width
//  CNT_W   32  retired-instruction counter width
// PORTS
//  clk              in   1      clock; all state updates on rising edge
//  rst              in   1      synchronous, active-high reset
//  id_wb            in   2      decode wb bundle: [1]=RegWrite, [0]=MemToReg
//  id_mem           in   3      decode mem bundle: [2]=Branch, [1]=MemRead, [0]=MemWrite
//  id_ex            in   4      decode ex bundle (ALU control), opaque here
//  id_valid         in   1      IF/ID holds a real instruction
//  id_rs, id_rt     in   REG_W  source registers of instruction in decode
//  id_dest          in   REG_W  destination register selected in decode
//  ex_zero          in   1      ALU zero flag of instruction in EX
//  stall            out  1      load-use stall; holds PC and IF/ID (combinational)
//  flush_ifid       out  1      branch taken; fetch discards IF/ID (combinational)
//  pcsrc            out  1      select branch target (= flush_ifid)
//  ex_alu_ctrl      out  4      ID/EX ex bundle
//  mem_read         out  1      EX/MEM MemRead
//  mem_write        out  1      EX/MEM MemWrite
//  mem_reg_write    out  1      EX/MEM RegWrite (for forwarding)
//  mem_dest         out  REG_W  EX/MEM destination
//  wb_reg_write     out  1      MEM/WB RegWrite
//  wb_mem_to_reg    out  1      MEM/WB MemToReg
//  wb_dest          out  REG_W  MEM/WB destination
//  retired          out  CNT_W  count of valid instructions leaving WB
// BEHAVIOUR
//  - Reset: all stage registers are cleared (bundles 0, dest 0, valid 0, zero 0), and retired is set to 0.
//    - This makes every registered output 0 in the cycle after rst=1.
//    - rst mid-operation discards all in-flight instructions and takes priority over flush and stall.
//  - Latency: an id_* bundle appears on ex_* outputs 1 cycle later, on mem_* outputs 2 cycles later, and on wb_* outputs 3 cycles later.
//  - Bubble: all bundle bits are 0 and valid=0; dest is held at 0.
//  - Load-use hazard:
//    - stall=1 when idex_MemRead & idex_valid & id_valid & idex_dest!=0 & (idex_dest==id_rs | idex_dest==id_rt).
//    - On stall, ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.
//    - The instruction in decode is re-presented next cycle, so exactly one bubble is inserted per load-use.
//  - Branch resolution:
//    - EX/MEM captures ex_zero. pcsrc = exmem_Branch & exmem_zero & exmem_valid.
//    - On pcsrc=1, ID/EX and EX/MEM load bubbles (wrong-path instructions) and flush_ifid=1.
//    - MEM/WB takes the branch itself.
//  - Priority: rst > pcsrc > stall. stall is forced to 0 while pcsrc=1.
//  - Register 0: a dest of 0 never raises a hazard. RegWrite with dest 0 is passed through unchanged; the regfile ignores it.
//  - Retire counter: increments by 1 each cycle MEM/WB valid=1 and wraps at 2^CNT_W-1 to 0. Bubbles and flushed instructions never count.
//  - id_valid=0 is treated exactly as a bubble entering ID/EX, whatever id_wb/id_mem/id_ex carry.
// STRUCTURE
//  - mips_ctrl_pkg holds:
//    - bundle widths (WB_W=2, MEM_W=3, EX_W=4)
//    - bit indices WB_REGWRITE=1, WB_MEMTOREG=0, MEM_BRANCH=2, MEM_MEMREAD=1, MEM_MEMWRITE=0
//    - the all-zero bubble constants
//    - the opcode/funct constants shared with decode control
//  - Sub-module hazard_detect (combinational): inputs are idex MemRead/valid/dest, id_valid, id_rs and id_rt; output is stall_raw.
//  - The top gates stall_raw with pcsrc.
// TESTING
//  1. rst=1 for 2 cycles with random id_* -> all outputs 0 and retired=0. Release rst, then feed 4 ADDs (id_wb=2'b10, dest 1..4) -> wb_reg_write=1 with wb_dest=1,2,3,4 on cycles 3..6 and retired=4.
//  2. LW r5 then ADD using rs=5 -> stall=1 for exactly 1 cycle and a bubble in EX (ex_alu_ctrl=0). The ADD reaches WB 1 cycle later than without the hazard; retired counts 2.
//  3. LW r0 then a consumer of r0 -> stall stays 0. A LW r5 followed by a consumer that has id_valid=0 -> stall=0.
//  4. BEQ (id_mem=3'b100) with ex_zero=1, followed by 2 SWs -> pcsrc=flush_ifid=1 for 1 cycle when BEQ is in MEM. Neither SW ever asserts mem_write; retired counts only the BEQ.
//  5. BEQ with ex_zero=0 -> pcsrc stays 0 and the following instructions retire normally.
//  6. Flush and load-use in the same cycle (BEQ taken in MEM, LW in EX, dependent in ID) -> stall=0 and flush_ifid=1. Separately, preload retired=2^CNT_W-1 via a force, then retire 1 -> retired=0. Assert rst mid-stream -> no stale RegWrite appears after reset.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
//   Shared definitions for the decode control unit and the control pipeline:
//   control-bundle widths, bit positions inside each bundle, the all-zero
//   bubble constants, and the opcode/funct encodings decode works from.
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

  // Bundle widths
  localparam int WB_W  = 2;
  localparam int MEM_W = 3;
  localparam int EX_W  = 4;

  // Bit positions inside the bundles
  localparam int WB_REGWRITE  = 1;
  localparam int WB_MEMTOREG  = 0;
  localparam int MEM_BRANCH   = 2;
  localparam int MEM_MEMREAD  = 1;
  localparam int MEM_MEMWRITE = 0;

  // Bubble (no-op) contents for each bundle
  localparam logic [WB_W-1:0]  WB_BUBBLE  = '0;
  localparam logic [MEM_W-1:0] MEM_BUBBLE = '0;
  localparam logic [EX_W-1:0]  EX_BUBBLE  = '0;

  // Opcodes shared with decode control
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type funct codes shared with decode control
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  // Bundle field helpers
  function automatic logic is_load(input logic [MEM_W-1:0] m);
    return m[MEM_MEMREAD];
  endfunction

  function automatic logic is_branch(input logic [MEM_W-1:0] m);
    return m[MEM_BRANCH];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//   Combinational load-use detector. Raises stall_raw when the instruction
//   in EX is a real load whose destination is a nonzero register read by
//   the real instruction currently in decode.
//
//   Ports
//     idex_mem_read  in   1      MemRead of the instruction in EX
//     idex_valid     in   1      EX holds a real instruction
//     idex_dest      in   REG_W  destination of the instruction in EX
//     id_valid       in   1      decode holds a real instruction
//     id_rs, id_rt   in   REG_W  source registers of the instruction in decode
//     stall_raw      out  1      load-use hazard before branch priority
// ---------------------------------------------------------------------------
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             idex_mem_read,
  input  logic             idex_valid,
  input  logic [REG_W-1:0] idex_dest,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             stall_raw
);

  logic dest_nz;
  logic src_match;

  // r0 is hard-wired to zero, so a load into it never produces a value to wait for
  assign dest_nz   = (idex_dest != '0);
  assign src_match = (idex_dest == id_rs) || (idex_dest == id_rt);
  assign stall_raw = idex_mem_read && idex_valid && id_valid && dest_nz && src_match;

endmodule

// File: rtl/ctrl_pipeline.sv
// ---------------------------------------------------------------------------
// ctrl_pipeline
//   Carries the decode control bundles through the ID/EX, EX/MEM and MEM/WB
//   registers and unpacks them into per-stage strobes. Inserts one bubble
//   per load-use hazard, resolves branches in MEM (discarding the two
//   wrong-path instructions behind the branch) and counts retirements.
//
//   Ports
//     clk, rst                    clock; synchronous active-high reset
//     id_wb/id_mem/id_ex          control bundles from decode
//     id_valid                    IF/ID holds a real instruction
//     id_rs, id_rt, id_dest       register specifiers of the decode instruction
//     ex_zero                     ALU zero flag of the instruction in EX
//     stall                       hold PC and IF/ID (combinational)
//     flush_ifid, pcsrc           branch taken: discard IF/ID, select target
//     ex_alu_ctrl                 ID/EX ALU control
//     mem_read/mem_write          EX/MEM memory strobes
//     mem_reg_write, mem_dest     EX/MEM write-back info for forwarding
//     wb_reg_write, wb_mem_to_reg MEM/WB write-back strobes
//     wb_dest                     MEM/WB destination register
//     retired                     count of valid instructions leaving WB
// ---------------------------------------------------------------------------
module ctrl_pipeline
  import mips_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       id_wb,
  input  logic [2:0]       id_mem,
  input  logic [3:0]       id_ex,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             ex_zero,
  output logic             stall,
  output logic             flush_ifid,
  output logic             pcsrc,
  output logic [3:0]       ex_alu_ctrl,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_reg_write,
  output logic [REG_W-1:0] mem_dest,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic [REG_W-1:0] wb_dest,
  output logic [CNT_W-1:0] retired
);

  // ID/EX stage register
  logic [WB_W-1:0]  wb_p0;
  logic [MEM_W-1:0] mem_p0;
  logic [EX_W-1:0]  ex_p0;
  logic [REG_W-1:0] dest_p0;
  logic             vld_p0;

  // EX/MEM stage register
  logic [WB_W-1:0]  wb_p1;
  logic [MEM_W-1:0] mem_p1;
  logic [REG_W-1:0] dest_p1;
  logic             zero_p1;
  logic             vld_p1;

  // MEM/WB stage register
  logic [WB_W-1:0]  wb_p2;
  logic [REG_W-1:0] dest_p2;
  logic             vld_p2;

  logic [CNT_W-1:0] ret_cnt;

  logic stall_raw;
  logic take_branch;
  logic hold_id;
  logic bubble_p0;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard (
    .idex_mem_read (is_load(mem_p0)),
    .idex_valid    (vld_p0),
    .idex_dest     (dest_p0),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .stall_raw     (stall_raw)
  );

  // A taken branch discards whatever sits in decode, so there is nothing
  // left to stall for: branch resolution wins over the load-use hazard.
  assign take_branch = is_branch(mem_p1) && zero_p1 && vld_p1;
  assign hold_id     = stall_raw && !take_branch;

  // Decode feeds a bubble on a flush, a stall, or when it holds no instruction
  assign bubble_p0 = take_branch || hold_id || !id_valid;

  assign stall      = hold_id;
  assign flush_ifid = take_branch;
  assign pcsrc      = take_branch;

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_p0   <= WB_BUBBLE;
      mem_p0  <= MEM_BUBBLE;
      ex_p0   <= EX_BUBBLE;
      dest_p0 <= '0;
      vld_p0  <= 1'b0;
    end else if (bubble_p0) begin
      wb_p0   <= WB_BUBBLE;
      mem_p0  <= MEM_BUBBLE;
      ex_p0   <= EX_BUBBLE;
      dest_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      wb_p0   <= id_wb;
      mem_p0  <= id_mem;
      ex_p0   <= id_ex;
      dest_p0 <= id_dest;
      vld_p0  <= 1'b1;
    end
  end

  // ---- EX -> MEM boundary ----
  always_ff @(posedge clk) begin
    if (rst || take_branch) begin
      wb_p1   <= WB_BUBBLE;
      mem_p1  <= MEM_BUBBLE;
      dest_p1 <= '0;
      zero_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      wb_p1   <= wb_p0;
      mem_p1  <= mem_p0;
      dest_p1 <= dest_p0;
      zero_p1 <= ex_zero;
      vld_p1  <= vld_p0;
    end
  end

  // ---- MEM -> WB boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_p2   <= WB_BUBBLE;
      dest_p2 <= '0;
      vld_p2  <= 1'b0;
    end else begin
      wb_p2   <= wb_p1;
      dest_p2 <= dest_p1;
      vld_p2  <= vld_p1;
    end
  end

  // ---- WB retirement ----
  // Plain binary wrap: all-ones plus one rolls over to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_cnt <= '0;
    end else if (vld_p2) begin
      ret_cnt <= ret_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign ex_alu_ctrl   = ex_p0;
  assign mem_read      = mem_p1[MEM_MEMREAD];
  assign mem_write     = mem_p1[MEM_MEMWRITE];
  assign mem_reg_write = wb_p1[WB_REGWRITE];
  assign mem_dest      = dest_p1;
  assign wb_reg_write  = wb_p2[WB_REGWRITE];
  assign wb_mem_to_reg = wb_p2[WB_MEMTOREG];
  assign wb_dest       = dest_p2;
  assign retired       = ret_cnt;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipeline
//   Directed scenarios followed by randomized traffic. A behavioural model
//   tracks which instruction occupies EX, MEM and WB and how many have
//   retired; every cycle the DUT strobes are compared against it.
// ---------------------------------------------------------------------------
module tb_ctrl_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  id_wb;
  logic [2:0]  id_mem;
  logic [3:0]  id_ex;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        ex_zero;
  logic        stall, flush_ifid, pcsrc;
  logic [3:0]  ex_alu_ctrl;
  logic        mem_read, mem_write, mem_reg_write;
  logic [4:0]  mem_dest;
  logic        wb_reg_write, wb_mem_to_reg;
  logic [4:0]  wb_dest;
  logic [31:0] retired;

  ctrl_pipeline dut (
    .clk           (clk),
    .rst           (rst),
    .id_wb         (id_wb),
    .id_mem        (id_mem),
    .id_ex         (id_ex),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_dest       (id_dest),
    .ex_zero       (ex_zero),
    .stall         (stall),
    .flush_ifid    (flush_ifid),
    .pcsrc         (pcsrc),
    .ex_alu_ctrl   (ex_alu_ctrl),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_reg_write (mem_reg_write),
    .mem_dest      (mem_dest),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_dest       (wb_dest),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] wb;
    logic [2:0] mem;
    logic [3:0] ex;
    logic [4:0] rs, rt, dest;
    logic       valid;
  } ins_t;

  // An instruction as it sits in a pipeline slot of the model
  typedef struct {
    logic [1:0] wb;
    logic [2:0] mem;
    logic [3:0] ex;
    logic [4:0] dest;
    logic       valid;
    logic       zero;
  } slot_t;

  slot_t       m_ex, m_mem, m_wb;
  logic [31:0] m_ret;
  logic        last_st;

  int n_chk = 0, n_fail = 0;
  int n_stall = 0, n_flush = 0, n_memw = 0, n_wbw = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic slot_t empty_slot();
    slot_t s;
    s.wb = 0; s.mem = 0; s.ex = 0; s.dest = 0; s.valid = 0; s.zero = 0;
    return s;
  endfunction

  function automatic ins_t mk(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] d);
    ins_t i;
    i.wb = wb; i.mem = mem; i.ex = ex; i.rs = rs; i.rt = rt; i.dest = d; i.valid = 1'b1;
    return i;
  endfunction

  function automatic ins_t add_i(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    return mk(2'b10, 3'b000, 4'b0010, s, t, d);
  endfunction
  function automatic ins_t lw_i(input logic [4:0] d, input logic [4:0] base);
    return mk(2'b11, 3'b010, 4'b0010, base, d, d);
  endfunction
  function automatic ins_t sw_i(input logic [4:0] base, input logic [4:0] t);
    return mk(2'b00, 3'b001, 4'b0010, base, t, 5'd0);
  endfunction
  function automatic ins_t beq_i(input logic [4:0] s, input logic [4:0] t);
    return mk(2'b00, 3'b100, 4'b0110, s, t, 5'd0);
  endfunction
  // Not a real instruction: bundles carry junk that must be ignored
  function automatic ins_t nop_i();
    ins_t i;
    i.wb = 2'($urandom); i.mem = 3'($urandom); i.ex = 4'($urandom);
    i.rs = 5'($urandom); i.rt = 5'($urandom); i.dest = 5'($urandom);
    i.valid = 1'b0;
    return i;
  endfunction

  // One clock: drive inputs, check combinational outputs, advance model, check registers
  task automatic cycle(input logic r, input ins_t i, input logic z);
    logic  br_taken, ld_use;
    slot_t n_ex, n_mem, n_wb;
    logic [31:0] n_ret;
    rst = r; id_wb = i.wb; id_mem = i.mem; id_ex = i.ex; id_valid = i.valid;
    id_rs = i.rs; id_rt = i.rt; id_dest = i.dest; ex_zero = z;
    #1;
    br_taken = m_mem.valid && m_mem.mem[2] && m_mem.zero;
    ld_use   = !br_taken && m_ex.valid && m_ex.mem[1] && i.valid && (m_ex.dest != 0) &&
               (m_ex.dest == i.rs || m_ex.dest == i.rt);
    last_st  = ld_use;
    chk("stall", stall, ld_use);
    chk("flush_ifid", flush_ifid, br_taken);
    chk("pcsrc", pcsrc, br_taken);
    if (stall) n_stall++;
    if (flush_ifid) n_flush++;

    if (r) begin
      n_ex = empty_slot(); n_mem = empty_slot(); n_wb = empty_slot(); n_ret = 0;
    end else begin
      n_ret = m_wb.valid ? m_ret + 1 : m_ret;
      n_wb  = m_mem;
      if (br_taken) n_mem = empty_slot();
      else begin n_mem = m_ex; n_mem.zero = z; end
      if (br_taken || ld_use || !i.valid) n_ex = empty_slot();
      else begin
        n_ex.wb = i.wb; n_ex.mem = i.mem; n_ex.ex = i.ex; n_ex.dest = i.dest;
        n_ex.valid = 1'b1; n_ex.zero = 1'b0;
      end
    end

    @(posedge clk); #1;
    m_ex = n_ex; m_mem = n_mem; m_wb = n_wb; m_ret = n_ret;
    chk("ex_alu_ctrl", ex_alu_ctrl, m_ex.ex);
    chk("mem_read", mem_read, m_mem.mem[1]);
    chk("mem_write", mem_write, m_mem.mem[0]);
    chk("mem_reg_write", mem_reg_write, m_mem.wb[1]);
    chk("mem_dest", mem_dest, m_mem.dest);
    chk("wb_reg_write", wb_reg_write, m_wb.wb[1]);
    chk("wb_mem_to_reg", wb_mem_to_reg, m_wb.wb[0]);
    chk("wb_dest", wb_dest, m_wb.dest);
    chk("retired", retired, m_ret);
    if (mem_write) n_memw++;
    if (wb_reg_write) n_wbw++;
  endtask

  // Present one instruction, re-presenting it while decode is stalled
  task automatic issue(input ins_t i, input logic z);
    cycle(1'b0, i, z);
    for (int k = 0; k < 4 && last_st; k++) cycle(1'b0, i, z);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, nop_i(), 1'b0);
  endtask

  int s0, f0, w0, r0, wb0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_ex = empty_slot(); m_mem = empty_slot(); m_wb = empty_slot(); m_ret = 0; last_st = 0;

    // Test 1: two reset cycles with junk on the inputs, then four ADDs
    rst = 1'b1;
    begin
      ins_t j; j = nop_i(); j.valid = 1'b1;
      id_wb = j.wb; id_mem = j.mem; id_ex = j.ex; id_valid = 1'b1;
      id_rs = j.rs; id_rt = j.rt; id_dest = j.dest; ex_zero = 1'b1;
    end
    @(posedge clk); #1;
    begin
      ins_t j; j = nop_i(); j.valid = 1'b1;
      cycle(1'b1, j, 1'b1);
    end
    chk("t1_reset_retired", retired, 32'd0);
    chk("t1_reset_wb_reg_write", wb_reg_write, 1'b0);
    wb0 = n_wbw;
    for (int d = 1; d <= 4; d++) issue(add_i(5'(d), 5'd0, 5'd0), 1'b0);
    drain(3);
    chk("t1_retired", retired, 32'd4);
    chk("t1_wb_writes", n_wbw - wb0, 4);
    drain(2);

    // Test 2: LW r5 followed by a consumer of r5
    s0 = n_stall; r0 = retired;
    cycle(1'b0, lw_i(5'd5, 5'd1), 1'b0);
    cycle(1'b0, add_i(5'd6, 5'd5, 5'd2), 1'b0);
    chk("t2_bubble_ex", ex_alu_ctrl, 4'd0);
    cycle(1'b0, add_i(5'd6, 5'd5, 5'd2), 1'b0);
    drain(5);
    chk("t2_stalls", n_stall - s0, 1);
    chk("t2_retired", retired - r0, 2);

    // Test 3: load into r0, and a load followed by a non-instruction
    s0 = n_stall;
    issue(lw_i(5'd0, 5'd1), 1'b0);
    issue(add_i(5'd7, 5'd0, 5'd0), 1'b0);
    issue(lw_i(5'd5, 5'd1), 1'b0);
    begin
      ins_t c; c = add_i(5'd7, 5'd5, 5'd5); c.valid = 1'b0;
      issue(c, 1'b0);
    end
    drain(4);
    chk("t3_stalls", n_stall - s0, 0);

    // Test 4: taken branch followed by two stores
    f0 = n_flush; w0 = n_memw; r0 = retired;
    issue(beq_i(5'd1, 5'd2), 1'b1);
    issue(sw_i(5'd1, 5'd3), 1'b1);
    issue(sw_i(5'd1, 5'd4), 1'b1);
    drain(5);
    chk("t4_flushes", n_flush - f0, 1);
    chk("t4_mem_writes", n_memw - w0, 0);
    chk("t4_retired", retired - r0, 1);

    // Test 5: untaken branch, the stores proceed
    f0 = n_flush; w0 = n_memw; r0 = retired;
    issue(beq_i(5'd1, 5'd2), 1'b0);
    issue(sw_i(5'd1, 5'd3), 1'b0);
    issue(sw_i(5'd1, 5'd4), 1'b0);
    drain(5);
    chk("t5_flushes", n_flush - f0, 0);
    chk("t5_mem_writes", n_memw - w0, 2);
    chk("t5_retired", retired - r0, 3);

    // Test 6a: flush and load-use in the same cycle
    s0 = n_stall; f0 = n_flush; r0 = retired;
    issue(beq_i(5'd1, 5'd2), 1'b1);
    issue(lw_i(5'd5, 5'd1), 1'b1);
    issue(add_i(5'd6, 5'd5, 5'd0), 1'b1);
    drain(5);
    chk("t6_stalls", n_stall - s0, 0);
    chk("t6_flushes", n_flush - f0, 1);
    chk("t6_retired", retired - r0, 1);

    // Test 6b: counter wrap
    force dut.ret_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.ret_cnt;
    m_ret = 32'hFFFF_FFFF;
    chk("t6_preload", retired, 32'hFFFF_FFFF);
    issue(add_i(5'd3, 5'd0, 5'd0), 1'b0);
    drain(4);
    chk("t6_wrap", retired, 32'd0);

    // Test 6c: reset with instructions in flight
    for (int d = 1; d <= 3; d++) issue(add_i(5'(d + 8), 5'd0, 5'd0), 1'b0);
    cycle(1'b1, nop_i(), 1'b0);
    wb0 = n_wbw;
    drain(5);
    chk("t6_no_stale_write", n_wbw - wb0, 0);
    chk("t6_reset_retired", retired, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      ins_t i;
      int sel;
      logic z;
      sel = $urandom_range(0, 9);
      z   = 1'($urandom);
      case (sel)
        0, 1, 2, 3: i = add_i(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        4, 5:       i = lw_i(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        6:          i = sw_i(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        7:          i = beq_i(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        default:    i = nop_i();
      endcase
      if ($urandom_range(0, 79) == 0) cycle(1'b1, i, z);
      else issue(i, z);
    end
    drain(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
